// File: rtl/probe_pkg.sv
// Shared types for the logic-probe comparator sequencer: mode codes, DAC threshold table, FSM states.
// Pure definitions; no latency and no flow control.
package probe_pkg;

   localparam logic [1:0] MODE_TTL       = 2'd0;
   localparam logic [1:0] MODE_CMOS5     = 2'd1;
   localparam logic [1:0] MODE_CMOS3V3   = 2'd2;
   localparam logic [1:0] MODE_LVCMOS1V8 = 2'd3;

   typedef enum logic [1:0] {
      SETTLE_HI = 2'd0,
      SAMPLE_HI = 2'd1,
      SETTLE_LO = 2'd2,
      SAMPLE_LO = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [3:0] hi;
      logic [3:0] lo;
   } thr_t;

   function automatic thr_t thr_lookup(input logic [1:0] mode);
      thr_t t;
      case (mode)
         MODE_TTL:       t = '{hi: 4'd6,  lo: 4'd2};
         MODE_CMOS5:     t = '{hi: 4'd11, lo: 4'd5};
         MODE_CMOS3V3:   t = '{hi: 4'd7,  lo: 4'd3};
         MODE_LVCMOS1V8: t = '{hi: 4'd4,  lo: 4'd1};
         default:        t = '{hi: 4'd6,  lo: 4'd2};
      endcase
      return t;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for one asynchronous bit; 2-cycle latency, no flow control.
module bit_sync (
   input  logic clk,
   input  logic nreset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/comp_mux_sequencer.sv
// Time-multiplexes one comparator between high and low probe thresholds via a shared DAC.
// One result pair every 2*(SETTLE_CYCLES+1) cycles; enable low or a mode change restarts the sequence.
module comp_mux_sequencer
   import probe_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       enable,
   input  logic [1:0] mode,
   input  logic       comp_out,
   output logic [3:0] dac_value,
   output logic       comp_data_hi,
   output logic       comp_data_lo,
   output logic       sample_valid
);

   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);
   localparam thr_t       THR_RST  = thr_lookup(MODE_TTL);

   seq_state_t state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [1:0] mode_q;
   logic       hi_tmp, hi_tmp_nxt;
   logic       comp_s;
   logic [3:0] dac_nxt;
   logic       hi_nxt, lo_nxt, valid_nxt;
   logic       restart;
   thr_t       thr;

   bit_sync u_comp_sync (
      .clk    (clk),
      .nreset (nreset),
      .d      (comp_out),
      .q      (comp_s)
   );

   // Thresholds follow the incoming mode so the DAC already matches mode_q on the edge that loads it.
   assign thr     = thr_lookup(mode);
   assign restart = !enable || (mode != mode_q);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      hi_tmp_nxt = hi_tmp;
      dac_nxt    = dac_value;
      hi_nxt     = comp_data_hi;
      lo_nxt     = comp_data_lo;
      valid_nxt  = 1'b0;
      if (restart) begin
         state_nxt  = SETTLE_HI;
         cnt_nxt    = 8'd0;
         hi_tmp_nxt = 1'b0;
         dac_nxt    = thr.hi;
      end else begin
         case (state)
            SETTLE_HI: begin
               if (cnt == CNT_LAST) begin
                  state_nxt = SAMPLE_HI;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
            SAMPLE_HI: begin
               hi_tmp_nxt = comp_s;
               state_nxt  = SETTLE_LO;
               cnt_nxt    = 8'd0;
               dac_nxt    = thr.lo;
            end
            SETTLE_LO: begin
               if (cnt == CNT_LAST) begin
                  state_nxt = SAMPLE_LO;
                  cnt_nxt   = 8'd0;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
            SAMPLE_LO: begin
               hi_nxt    = hi_tmp;
               lo_nxt    = ~comp_s;
               valid_nxt = 1'b1;
               state_nxt = SETTLE_HI;
               cnt_nxt   = 8'd0;
               dac_nxt   = thr.hi;
            end
            default: begin
               state_nxt = SETTLE_HI;
               cnt_nxt   = 8'd0;
               dac_nxt   = thr.hi;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state        <= SETTLE_HI;
         cnt          <= 8'd0;
         mode_q       <= MODE_TTL;
         hi_tmp       <= 1'b0;
         dac_value    <= THR_RST.hi;
         comp_data_hi <= 1'b0;
         comp_data_lo <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         mode_q       <= mode;
         hi_tmp       <= hi_tmp_nxt;
         dac_value    <= dac_nxt;
         comp_data_hi <= hi_nxt;
         comp_data_lo <= lo_nxt;
         sample_valid <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_comp_mux_sequencer.sv
// Bench for comp_mux_sequencer: position-in-sequence reference model plus directed scenario checks.
module tb_comp_mux_sequencer;

   localparam int SC = 16;
   localparam int P  = 2 * (SC + 1);

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       comp_out;
   logic [3:0] dac_value;
   logic       comp_data_hi, comp_data_lo, sample_valid;
   logic [3:0] vin = 4'd0;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   int HI_T [4] = '{6, 11, 7, 4};
   int LO_T [4] = '{2, 5, 3, 1};

   always #5 clk = ~clk;

   // Ideal comparator: probe voltage code against the DAC code currently driven.
   assign comp_out = (vin > dac_value);

   comp_mux_sequencer #(.SETTLE_CYCLES(SC)) dut (
      .clk          (clk),
      .nreset       (nreset),
      .enable       (enable),
      .mode         (mode),
      .comp_out     (comp_out),
      .dac_value    (dac_value),
      .comp_data_hi (comp_data_hi),
      .comp_data_lo (comp_data_lo),
      .sample_valid (sample_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: position 0..P-1 inside the sequence; comparator seen with two edges of delay.
   int         m_pos;
   logic [1:0] m_mode;
   logic       m_c1, m_c2, m_hitmp;
   logic [3:0] m_dac;
   logic       m_hi, m_lo, m_valid;

   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         m_pos   <= 0;
         m_mode  <= 2'd0;
         m_c1    <= 1'b0;
         m_c2    <= 1'b0;
         m_hitmp <= 1'b0;
         m_dac   <= 4'd6;
         m_hi    <= 1'b0;
         m_lo    <= 1'b0;
         m_valid <= 1'b0;
      end else begin
         m_valid <= 1'b0;
         m_mode  <= mode;
         m_c1    <= comp_out;
         m_c2    <= m_c1;
         if (!enable || mode != m_mode) begin
            m_pos <= 0;
            m_dac <= 4'(HI_T[mode]);
         end else begin
            if (m_pos == SC) m_hitmp <= m_c2;
            if (m_pos == P - 1) begin
               m_hi    <= m_hitmp;
               m_lo    <= ~m_c2;
               m_valid <= 1'b1;
            end
            m_pos <= (m_pos + 1) % P;
            m_dac <= (((m_pos + 1) % P) <= SC) ? 4'(HI_T[mode]) : 4'(LO_T[mode]);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_dac",   32'(dac_value),    32'(m_dac));
         chk("model_hi",    32'(comp_data_hi), 32'(m_hi));
         chk("model_lo",    32'(comp_data_lo), 32'(m_lo));
         chk("model_valid", 32'(sample_valid), 32'(m_valid));
      end
   end

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sample_valid !== 1'b1 && n < max);
   endtask

   initial begin
      int n;
      int vcount;
      logic prev_hi, prev_lo;

      nreset = 1'b0; enable = 1'b1; mode = 2'd0; vin = 4'd0;
      ticks(3);
      chk_on = 1'b1;
      chk("rst_dac",   32'(dac_value),    6);
      chk("rst_hi",    32'(comp_data_hi), 0);
      chk("rst_lo",    32'(comp_data_lo), 0);
      chk("rst_valid", 32'(sample_valid), 0);
      nreset = 1'b1;

      // Mode 0, probe low: DAC alternates 6/2 every 17 cycles.
      ticks(16);
      chk("m0_dac_hi_phase", 32'(dac_value), 6);
      ticks(1);
      chk("m0_dac_lo_phase", 32'(dac_value), 2);
      wait_valid(40, n);
      chk("first_valid_cycle", n + 17, 34);
      chk("low_probe_hi", 32'(comp_data_hi), 0);
      chk("low_probe_lo", 32'(comp_data_lo), 1);

      vin = 4'd9;
      wait_valid(40, n);
      chk("vin9_period", n, 34);
      chk("vin9_hi", 32'(comp_data_hi), 1);
      chk("vin9_lo", 32'(comp_data_lo), 0);
      vin = 4'd4;
      wait_valid(40, n);
      chk("vin4_hi", 32'(comp_data_hi), 0);
      chk("vin4_lo", 32'(comp_data_lo), 0);

      // Enable dropped for 50 cycles in the middle of the low settle.
      ticks(20);
      enable = 1'b0;
      vcount = 0;
      repeat (50) begin
         @(negedge clk);
         if (sample_valid) vcount++;
      end
      chk("dis_valids", vcount, 0);
      chk("dis_dac", 32'(dac_value), 6);
      enable = 1'b1;
      wait_valid(40, n);
      chk("en_restart_period", n, 34);

      // Mode 0->1 at low-settle cycle 10.
      vin = 4'd9;
      wait_valid(40, n);
      ticks(27);
      mode = 2'd1;
      ticks(1);
      chk("mchg_dac", 32'(dac_value), 11);
      ticks(17);
      chk("mchg_dac_lo", 32'(dac_value), 5);
      chk("mchg_hold_hi", 32'(comp_data_hi), 1);
      chk("mchg_hold_lo", 32'(comp_data_lo), 0);
      wait_valid(40, n);
      chk("mchg_valid_delay", n + 18, 35);
      chk("m1_hi", 32'(comp_data_hi), 0);
      chk("m1_lo", 32'(comp_data_lo), 0);

      // Mode change landing exactly on the low sample cycle.
      vin = 4'd12;
      ticks(33);
      prev_hi = comp_data_hi;
      prev_lo = comp_data_lo;
      mode = 2'd2;
      ticks(1);
      chk("slo_mchg_valid", 32'(sample_valid), 0);
      chk("slo_mchg_hi", 32'(comp_data_hi), 32'(prev_hi));
      chk("slo_mchg_lo", 32'(comp_data_lo), 32'(prev_lo));
      chk("slo_mchg_dac", 32'(dac_value), 7);
      wait_valid(40, n);
      chk("slo_mchg_delay", n + 1, 35);
      chk("m2_hi", 32'(comp_data_hi), 1);

      // Reset pulse during the high sample cycle.
      ticks(16);
      #2 nreset = 1'b0;
      #1;
      chk("arst_dac",   32'(dac_value),    6);
      chk("arst_hi",    32'(comp_data_hi), 0);
      chk("arst_lo",    32'(comp_data_lo), 0);
      chk("arst_valid", 32'(sample_valid), 0);
      ticks(2);
      mode = 2'd0;
      nreset = 1'b1;
      wait_valid(40, n);
      chk("arst_first_valid", n, 34);

      // Randomized traffic against the model.
      vcount = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (sample_valid) vcount++;
         if ($urandom_range(0, 7) == 0) vin = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
         if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      end
      chk("rand_valids_seen", 32'(vcount > 0), 1);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/comp_mux_sequencer.md
COMP_MUX_SEQUENCER -- requirements
Module: comp_mux_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, cycles the DAC is held before each comparator sample; legal range 3..255.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  run sequencer when 1; hold when 0.
REQ-005 SHALL have port mode  input  2  logic family select: 0 TTL, 1 CMOS5, 2 CMOS3V3, 3 LVCMOS1V8.
REQ-006 SHALL have port comp_out  input  1  asynchronous output of the single shared comparator, 1 when probe voltage > DAC voltage.
REQ-007 SHALL have port dac_value  output  4  threshold code driven to the shared DAC.
REQ-008 SHALL have port comp_data_hi  output  1  1 = probe above high threshold, to logicProbe1.
REQ-009 SHALL have port comp_data_lo  output  1  1 = probe below low threshold, to logicProbe1.
REQ-010 SHALL have port sample_valid  output  1  one-cycle pulse when comp_data_hi/lo update.

Function
REQ-011 SHALL use threshold codes (hi/lo): mode0 6/2, mode1 11/5, mode2 7/3, mode3 4/1.
REQ-012 SHALL pass comp_out through a 2-flop synchronizer before any use; synchronized value = comp_s.
REQ-013 SHALL implement FSM states SETTLE_HI, SAMPLE_HI, SETTLE_LO, SAMPLE_LO.
REQ-014 SETTLE_HI: dac_value = hi code of mode_q; 8-bit counter counts 0..SETTLE_CYCLES-1, then -> SAMPLE_HI.
REQ-015 SAMPLE_HI: capture hi_tmp = comp_s; dac_value still hi code; next -> SETTLE_LO, counter cleared.
REQ-016 SETTLE_LO: dac_value = lo code of mode_q; counts as REQ-014, then -> SAMPLE_LO.
REQ-017 SAMPLE_LO: comp_data_hi <= hi_tmp, comp_data_lo <= ~comp_s, both in the same edge; sample_valid = 1 for this one cycle; next -> SETTLE_HI, counter cleared.
REQ-018 Full sequence period SHALL be exactly 2*(SETTLE_CYCLES+1) cycles (34 at default); sample_valid period identical.
REQ-019 dac_value SHALL be registered and change only on the edge entering SETTLE_HI or SETTLE_LO.
REQ-020 mode SHALL be registered into mode_q each cycle; when mode differs from mode_q, FSM SHALL go to SETTLE_HI with counter cleared, discard hi_tmp, suppress sample_valid, and hold comp_data_hi/lo.
REQ-021 Mode change arriving in SAMPLE_LO SHALL take priority: no output update, no sample_valid.
REQ-022 enable = 0 SHALL force state SETTLE_HI, counter 0, sample_valid 0, outputs held; on enable = 1 the sequence SHALL start a full SETTLE_HI count.
REQ-023 enable = 0 and mode change in the same cycle SHALL behave as enable = 0 with mode_q updated.
REQ-024 Counter SHALL never wrap: it is cleared on every state exit.

Reset
REQ-025 nreset low SHALL asynchronously set state SETTLE_HI, counter 0, mode_q 0, synchronizer flops 0, hi_tmp 0.
REQ-026 Reset values: dac_value 6, comp_data_hi 0, comp_data_lo 0, sample_valid 0 (probe reads floating).
REQ-027 Reset asserted mid-sequence SHALL discard any partial sample; first sample_valid after release occurs at cycle 2*(SETTLE_CYCLES+1) with enable = 1 and mode stable.

Structure
REQ-028 Package probe_pkg SHALL hold the mode encoding constants, the hi/lo threshold table, and the FSM state type.
REQ-029 The 2-flop synchronizer SHALL be a sub-module named bit_sync (async active-low reset, reset value 0).
REQ-030 comp_mux_sequencer SHALL connect directly to logicProbe1 comp_data_hi, comp_data_lo, mode, with logicProbe1 dac_value unused.

Verification
REQ-031 Reset, mode 0, enable 1, comp_out = 0 -> dac_value alternates 6/2 every 17 cycles; first sample_valid at cycle 34; comp_data_hi 0, comp_data_lo 1.
REQ-032 Comparator model comp_out = (vin_code > dac_value), vin_code 9, mode 0 -> comp_data_hi 1, comp_data_lo 0; vin_code 4 -> both 0 after next sample_valid.
REQ-033 Mode 0->1 in SETTLE_LO cycle 10 -> dac_value 11 next cycle, no sample_valid for 34 cycles after change, outputs held; then codes 11/5.
REQ-034 Mode change exactly in SAMPLE_LO -> no sample_valid, outputs unchanged, restart at SETTLE_HI.
REQ-035 enable low for 50 cycles mid-SETTLE_LO -> dac_value 6, no sample_valid; enable high -> sample_valid exactly 34 cycles later.
REQ-036 nreset pulse during SAMPLE_HI -> all outputs to REQ-026 values immediately, first sample_valid 34 cycles after release.
